// File: rtl/dist_5nbits_if.sv
// Purpose : Bundles the element handshake of the 1-to-5 distributor with the
//           five lane outputs and their consumer ready strobes.
// Signals : in_valid/in_ready/select/ent - upstream element offer
//           sal1..sal5/val1..val5        - lane data and lane-occupied flags
//           rdy1..rdy5                   - per-lane consumer take strobes
// Modports: slave  - the distributor itself
//           master - the surrounding fabric (producer plus lane consumers)
interface dist_5nbits_if #(
   parameter int unsigned N = 20
) ();

   logic         in_valid;
   logic         in_ready;
   logic [2:0]   select;
   logic [N-1:0] ent;

   logic [N-1:0] sal1;
   logic [N-1:0] sal2;
   logic [N-1:0] sal3;
   logic [N-1:0] sal4;
   logic [N-1:0] sal5;

   logic         val1;
   logic         val2;
   logic         val3;
   logic         val4;
   logic         val5;

   logic         rdy1;
   logic         rdy2;
   logic         rdy3;
   logic         rdy4;
   logic         rdy5;

   modport slave (
      input  in_valid, select, ent,
      input  rdy1, rdy2, rdy3, rdy4, rdy5,
      output in_ready,
      output sal1, sal2, sal3, sal4, sal5,
      output val1, val2, val3, val4, val5
   );

   modport master (
      output in_valid, select, ent,
      output rdy1, rdy2, rdy3, rdy4, rdy5,
      input  in_ready,
      input  sal1, sal2, sal3, sal4, sal5,
      input  val1, val2, val3, val4, val5
   );

endinterface

// File: rtl/dist_5nbits.sv
// Purpose : 1-to-5 registered element distributor. Each accepted element is
//           written into one single-entry lane register (or all five on a
//           broadcast); each lane drains independently under its own ready.
//           Elements offered with an invalid select are accepted and dropped,
//           counted by a saturating counter and flagged by a sticky error.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           bus (slave)     - element handshake, lane data/valid, lane ready
//           drop_cnt        - saturating count of dropped elements
//           err             - sticky, set on the first drop
module dist_5nbits #(
   parameter int unsigned N   = 20,
   parameter int unsigned DCW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   dist_5nbits_if.slave    bus,
   output logic [DCW-1:0]  drop_cnt,
   output logic            err
);

   localparam int unsigned LANES = 5;
   localparam logic [DCW-1:0] DROP_MAX = '1;

   logic [LANES-1:0] rdy_vec;
   logic [LANES-1:0] lane_sel;
   logic [LANES-1:0] can_take;
   logic [LANES-1:0] load;
   logic             sel_invalid;
   logic             in_ready_c;
   logic             accept;

   logic [LANES-1:0] val_q;
   logic [LANES-1:0] val_d;
   logic [N-1:0]     sal_q [LANES];
   logic [N-1:0]     sal_d [LANES];
   logic [DCW-1:0]   drop_q;
   logic [DCW-1:0]   drop_d;
   logic             err_q;
   logic             err_d;

   assign rdy_vec = {bus.rdy5, bus.rdy4, bus.rdy3, bus.rdy2, bus.rdy1};

   // Select decode: one-hot lane mask, all-ones for broadcast, empty when invalid.
   always_comb begin
      lane_sel    = '0;
      sel_invalid = 1'b0;
      unique case (bus.select)
         3'b001:  lane_sel = 5'b00001;
         3'b010:  lane_sel = 5'b00010;
         3'b011:  lane_sel = 5'b00100;
         3'b100:  lane_sel = 5'b01000;
         3'b101:  lane_sel = 5'b10000;
         3'b111:  lane_sel = 5'b11111;
         default: sel_invalid = 1'b1;
      endcase
   end

   // A slot can take a new element when empty or being drained this cycle.
   assign can_take = ~val_q | rdy_vec;

   // Every targeted lane must be able to take; an invalid select targets none
   // and is therefore always ready. Independent of in_valid and ent.
   assign in_ready_c = sel_invalid | (&(can_take | ~lane_sel));
   assign accept     = bus.in_valid & in_ready_c;

   // Lane next state: a load wins over a drain, so drain+refill keeps val set.
   always_comb begin
      load  = '0;
      val_d = val_q;
      for (int k = 0; k < int'(LANES); k++) begin
         sal_d[k] = sal_q[k];
         load[k]  = accept & lane_sel[k];
         if (load[k]) begin
            val_d[k] = 1'b1;
            sal_d[k] = bus.ent;
         end else if (val_q[k] && rdy_vec[k]) begin
            val_d[k] = 1'b0;
         end
      end
   end

   // Drop accounting for accepted elements with an invalid select.
   always_comb begin
      drop_d = drop_q;
      err_d  = err_q;
      if (accept && sel_invalid) begin
         err_d = 1'b1;
         if (drop_q != DROP_MAX) begin
            drop_d = drop_q + DCW'(1);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q  <= '0;
         drop_q <= '0;
         err_q  <= 1'b0;
         for (int k = 0; k < int'(LANES); k++) begin
            sal_q[k] <= '0;
         end
      end else begin
         val_q  <= val_d;
         drop_q <= drop_d;
         err_q  <= err_d;
         for (int k = 0; k < int'(LANES); k++) begin
            sal_q[k] <= sal_d[k];
         end
      end
   end

   assign bus.in_ready = in_ready_c;

   assign bus.sal1 = sal_q[0];
   assign bus.sal2 = sal_q[1];
   assign bus.sal3 = sal_q[2];
   assign bus.sal4 = sal_q[3];
   assign bus.sal5 = sal_q[4];

   assign bus.val1 = val_q[0];
   assign bus.val2 = val_q[1];
   assign bus.val3 = val_q[2];
   assign bus.val4 = val_q[3];
   assign bus.val5 = val_q[4];

   assign drop_cnt = drop_q;
   assign err      = err_q;

endmodule

// File: tb/tb_dist_5nbits.sv
// Purpose : Self-checking bench for dist_5nbits: a table of directed vectors
//           applied one per cycle, plus hand-written sequences for drop-counter
//           saturation and asynchronous reset.
module tb_dist_5nbits;

   localparam int unsigned N   = 20;
   localparam int unsigned DCW = 8;

   logic           clk;
   logic           rst_n;
   logic [DCW-1:0] drop_cnt;
   logic           err;

   int errors;
   int checks;

   dist_5nbits_if #(.N(N)) bus ();

   dist_5nbits #(.N(N), .DCW(DCW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .drop_cnt (drop_cnt),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         vin;
      logic [2:0]   sel;
      logic [N-1:0] ent;
      logic [4:0]   rdy;       // bit0 = lane 1
      logic         exp_rdy;   // in_ready before the edge
      logic [4:0]   exp_val;   // val5..val1 after the edge
      int           chk_lane;  // lane whose sal is checked after the edge (0 = none)
      logic [N-1:0] exp_sal;
      int           exp_drop;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   function automatic vec_t mk(logic vin, logic [2:0] sel, logic [N-1:0] ent,
                               logic [4:0] rdy, logic exp_rdy, logic [4:0] exp_val,
                               int chk_lane, logic [N-1:0] exp_sal, int exp_drop);
      vec_t v;
      v.vin = vin; v.sel = sel; v.ent = ent; v.rdy = rdy;
      v.exp_rdy = exp_rdy; v.exp_val = exp_val;
      v.chk_lane = chk_lane; v.exp_sal = exp_sal; v.exp_drop = exp_drop;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] val_vec();
      return {bus.val5, bus.val4, bus.val3, bus.val2, bus.val1};
   endfunction

   function automatic logic [N-1:0] sal_of(int lane);
      case (lane)
         1:       return bus.sal1;
         2:       return bus.sal2;
         3:       return bus.sal3;
         4:       return bus.sal4;
         default: return bus.sal5;
      endcase
   endfunction

   task automatic drive(logic vin, logic [2:0] sel, logic [N-1:0] ent, logic [4:0] rdy);
      bus.in_valid = vin;
      bus.select   = sel;
      bus.ent      = ent;
      bus.rdy1 = rdy[0]; bus.rdy2 = rdy[1]; bus.rdy3 = rdy[2];
      bus.rdy4 = rdy[3]; bus.rdy5 = rdy[4];
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      drive(1'b0, 3'b000, '0, 5'b00000);

      //             vin  sel     ent        rdy       rdy   val      lane sal       drop
      vecs[0]  = mk(1'b1, 3'b011, 20'h0ABCD, 5'b00000, 1'b1, 5'b00100, 3, 20'h0ABCD, 0);
      vecs[1]  = mk(1'b1, 3'b011, 20'h12345, 5'b00000, 1'b0, 5'b00100, 3, 20'h0ABCD, 0);
      vecs[2]  = mk(1'b1, 3'b010, 20'h00011, 5'b00000, 1'b1, 5'b00110, 2, 20'h00011, 0);
      vecs[3]  = mk(1'b1, 3'b010, 20'h00022, 5'b00000, 1'b0, 5'b00110, 2, 20'h00011, 0);
      vecs[4]  = mk(1'b1, 3'b010, 20'h00022, 5'b00010, 1'b1, 5'b00110, 2, 20'h00022, 0);
      vecs[5]  = mk(1'b1, 3'b001, 20'h00101, 5'b00000, 1'b1, 5'b00111, 1, 20'h00101, 0);
      vecs[6]  = mk(1'b1, 3'b101, 20'h00555, 5'b00000, 1'b1, 5'b10111, 5, 20'h00555, 0);
      vecs[7]  = mk(1'b1, 3'b101, 20'h00666, 5'b00000, 1'b0, 5'b10111, 1, 20'h00101, 0);
      vecs[8]  = mk(1'b0, 3'b000, 20'h00777, 5'b11111, 1'b1, 5'b00000, 3, 20'h0ABCD, 0);
      vecs[9]  = mk(1'b1, 3'b111, 20'hFFFFF, 5'b00000, 1'b1, 5'b11111, 4, 20'hFFFFF, 0);
      vecs[10] = mk(1'b1, 3'b111, 20'h0AAAA, 5'b10111, 1'b0, 5'b01000, 4, 20'hFFFFF, 0);
      vecs[11] = mk(1'b1, 3'b111, 20'h0AAAA, 5'b11111, 1'b1, 5'b11111, 1, 20'h0AAAA, 0);
      vecs[12] = mk(1'b1, 3'b000, 20'h00001, 5'b00000, 1'b1, 5'b11111, 5, 20'h0AAAA, 1);
      vecs[13] = mk(1'b1, 3'b110, 20'h00002, 5'b00000, 1'b1, 5'b11111, 3, 20'h0AAAA, 2);
      vecs[14] = mk(1'b1, 3'b000, 20'h00003, 5'b00000, 1'b1, 5'b11111, 2, 20'h0AAAA, 3);
      vecs[15] = mk(1'b0, 3'b000, 20'h00000, 5'b00001, 1'b1, 5'b11110, 0, 20'h00000, 3);
      vecs[16] = mk(1'b1, 3'b100, 20'h00444, 5'b01000, 1'b1, 5'b11110, 4, 20'h00444, 3);
      vecs[17] = mk(1'b1, 3'b001, 20'h00111, 5'b00000, 1'b1, 5'b11111, 1, 20'h00111, 3);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_val", 32'(val_vec()), 32'h0);
      check("reset_drop", 32'(drop_cnt), 32'h0);
      check("reset_err", 32'(err), 32'h0);
      for (int k = 1; k <= 5; k++) check("reset_sal", 32'(sal_of(k)), 32'h0);

      // Table of directed vectors, one per cycle.
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].vin, vecs[i].sel, vecs[i].ent, vecs[i].rdy);
         #1;
         check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_val", i), 32'(val_vec()), 32'(vecs[i].exp_val));
         if (vecs[i].chk_lane != 0)
            check($sformatf("v%0d_sal%0d", i, vecs[i].chk_lane),
                  32'(sal_of(vecs[i].chk_lane)), 32'(vecs[i].exp_sal));
         check($sformatf("v%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].exp_drop));
         check($sformatf("v%0d_err", i), 32'(err), (vecs[i].exp_drop != 0) ? 32'h1 : 32'h0);
      end

      // Drop counter saturation: 3 drops so far, 300 more invalid elements.
      drive(1'b1, 3'b000, 20'h0BEEF, 5'b00000);
      repeat (251) @(posedge clk);
      #1;
      check("sat_254", 32'(drop_cnt), 32'd254);
      drive(1'b1, 3'b110, 20'h0BEEF, 5'b00000);
      @(posedge clk);
      #1;
      check("sat_255", 32'(drop_cnt), 32'd255);
      repeat (48) @(posedge clk);
      #1;
      check("sat_hold", 32'(drop_cnt), 32'd255);
      check("sat_ready", 32'(bus.in_ready), 32'h1);
      check("sat_val", 32'(val_vec()), 32'h1F);
      check("sat_err", 32'(err), 32'h1);

      // Asynchronous reset asserted mid-cycle with lanes occupied.
      drive(1'b0, 3'b000, '0, 5'b00000);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_val", 32'(val_vec()), 32'h0);
      check("async_drop", 32'(drop_cnt), 32'h0);
      check("async_err", 32'(err), 32'h0);
      for (int k = 1; k <= 5; k++) check("async_sal", 32'(sal_of(k)), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_val", 32'(val_vec()), 32'h0);
      check("post_reset_drop", 32'(drop_cnt), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
